// File: rtl/dbf_requant_if.sv
// Sample bus for dbf_requant: input beat (I/Q lanes + qualifier) and requantised output beat.
interface dbf_requant_if #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CH    = 4
) ();
  logic                  in_valid;
  logic [CH*IN_W-1:0]    data_i;
  logic [CH*IN_W-1:0]    data_q;
  logic                  out_valid;
  logic [CH*OUT_W-1:0]   data_out_i;
  logic [CH*OUT_W-1:0]   data_out_q;

  modport master (
    output in_valid, data_i, data_q,
    input  out_valid, data_out_i, data_out_q
  );

  modport slave (
    input  in_valid, data_i, data_q,
    output out_valid, data_out_i, data_out_q
  );
endinterface

// File: rtl/dbf_requant.sv
// Two-stage I/Q requantiser: arithmetic right shift + saturation, manual or frame-based auto shift.
// Define DBF_REQUANT_ROUND_EN for round-half-up before the shift; default build truncates.
module dbf_requant #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dbf_requant_if.slave bus,
  input  logic [5:0]   cut_ctl,
  input  logic         auto_en,
  input  logic [15:0]  frame_len,
  input  logic         sat_clr,
  output logic [15:0]  sat_cnt,
  output logic [5:0]   shift_used
);

  localparam int unsigned    MaxSh   = IN_W - OUT_W;
  localparam logic [5:0]     MaxSh6  = 6'(MaxSh);
  localparam logic [IN_W-1:0] PeakLim = {{(IN_W-1){1'b0}}, 1'b1} << (OUT_W - 1);

  typedef enum logic [1:0] {StIdle, StAcq, StUpdate} state_e;

  // |x| as ~x for negatives so the most negative input cannot overflow.
  function automatic logic [IN_W-1:0] abs_mag(input logic [IN_W-1:0] x);
    return x[IN_W-1] ? ~x : x;
  endfunction

  // Returns {saturated, y} for one lane.
  function automatic logic [OUT_W:0] requant(input logic [IN_W-1:0] x, input logic [5:0] sh);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] shd;
    ext = $signed({x[IN_W-1], x});
`ifdef DBF_REQUANT_ROUND_EN
    if (sh != 6'd0) ext = ext + $signed((IN_W+1)'(1) << (sh - 6'd1));
`endif
    shd = ext >>> sh;
    if ((&shd[IN_W:OUT_W-1]) || !(|shd[IN_W:OUT_W-1])) return {1'b0, shd[OUT_W-1:0]};
    return {1'b1, shd[IN_W], {(OUT_W-1){~shd[IN_W]}}};
  endfunction

  state_e          state_q;
  logic [IN_W-1:0] peak_q;
  logic [15:0]     cnt_q;
  logic [15:0]     len_q;
  logic [5:0]      auto_shift_q;

  logic [5:0]      cut_clamp;
  logic [5:0]      sh_sel;
  logic [15:0]     len_eff;
  logic [IN_W-1:0] beat_peak;
  logic [IN_W-1:0] peak_acc;
  logic [16:0]     cnt_inc;
  logic [5:0]      shift_calc;

  assign cut_clamp = (cut_ctl > MaxSh6) ? MaxSh6 : cut_ctl;
  assign sh_sel    = auto_en ? auto_shift_q : cut_clamp;
  assign len_eff   = (frame_len == 16'd0) ? 16'd1 : frame_len;
  assign peak_acc  = (beat_peak > peak_q) ? beat_peak : peak_q;
  assign cnt_inc   = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    beat_peak = '0;
    for (int k = 0; k < int'(CH); k++) begin
      if (abs_mag(bus.data_i[k*IN_W +: IN_W]) > beat_peak) begin
        beat_peak = abs_mag(bus.data_i[k*IN_W +: IN_W]);
      end
      if (abs_mag(bus.data_q[k*IN_W +: IN_W]) > beat_peak) begin
        beat_peak = abs_mag(bus.data_q[k*IN_W +: IN_W]);
      end
    end
  end

  // Descending scan leaves the smallest qualifying shift.
  always_comb begin
    shift_calc = MaxSh6;
    for (int s = int'(MaxSh); s >= 0; s--) begin
      if ((peak_q >> s) < PeakLim) shift_calc = 6'(s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      peak_q       <= '0;
      cnt_q        <= '0;
      len_q        <= 16'd1;
      auto_shift_q <= MaxSh6;
    end else if (!auto_en) begin
      state_q <= StIdle;
      peak_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StAcq;
          peak_q  <= '0;
          cnt_q   <= '0;
          len_q   <= len_eff;
        end
        StAcq: begin
          if (bus.in_valid) begin
            peak_q <= peak_acc;
            cnt_q  <= cnt_inc[15:0];
            if (cnt_inc == {1'b0, len_q}) state_q <= StUpdate;
          end
        end
        StUpdate: begin
          // A beat here used the old shift and opens the next frame.
          auto_shift_q <= shift_calc;
          len_q        <= len_eff;
          if (bus.in_valid) begin
            peak_q  <= beat_peak;
            cnt_q   <= 16'd1;
            state_q <= (len_eff == 16'd1) ? StUpdate : StAcq;
          end else begin
            peak_q  <= '0;
            cnt_q   <= '0;
            state_q <= StAcq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic                s1_valid_q;
  logic [CH*IN_W-1:0]  s1_di_q;
  logic [CH*IN_W-1:0]  s1_dq_q;
  logic [5:0]          s1_sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_di_q    <= '0;
      s1_dq_q    <= '0;
      s1_sh_q    <= MaxSh6;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_di_q <= bus.data_i;
        s1_dq_q <= bus.data_q;
        s1_sh_q <= sh_sel;
      end
    end
  end

  logic [CH*OUT_W-1:0] out_i_d;
  logic [CH*OUT_W-1:0] out_q_d;
  logic [CH-1:0]       sat_i;
  logic [CH-1:0]       sat_q;
  logic                any_sat;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    logic [OUT_W:0] ri;
    logic [OUT_W:0] rq;
    assign ri = requant(s1_di_q[k*IN_W +: IN_W], s1_sh_q);
    assign rq = requant(s1_dq_q[k*IN_W +: IN_W], s1_sh_q);
    assign out_i_d[k*OUT_W +: OUT_W] = ri[OUT_W-1:0];
    assign out_q_d[k*OUT_W +: OUT_W] = rq[OUT_W-1:0];
    assign sat_i[k] = ri[OUT_W];
    assign sat_q[k] = rq[OUT_W];
  end

  assign any_sat = |{sat_i, sat_q};

  logic                out_valid_q;
  logic [CH*OUT_W-1:0] out_i_q;
  logic [CH*OUT_W-1:0] out_q_q;
  logic [5:0]          shift_used_q;
  logic [15:0]         sat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      shift_used_q <= MaxSh6;
      sat_cnt_q    <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_i_q      <= out_i_d;
        out_q_q      <= out_q_d;
        shift_used_q <= s1_sh_q;
      end
      if (sat_clr) begin
        sat_cnt_q <= '0;
      end else if (s1_valid_q && any_sat && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_q <= sat_cnt_q + 16'd1;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.data_out_i = out_i_q;
  assign bus.data_out_q = out_q_q;
  assign shift_used     = shift_used_q;
  assign sat_cnt        = sat_cnt_q;

endmodule
